// File: rtl/load_responder_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// load_responder_if : core <-> data-memory responder request/response bundle
// Rev 1.0
// ----------------------------------------------------------------------------
interface load_responder_if #(
  parameter int W = 8,
  parameter int A = 8
);
  logic         ReqRead;
  logic         ReqWrite;
  logic [A-1:0] Addr;
  logic [W-1:0] WrData;
  logic         Busy;
  logic         LoadSet;
  logic [W-1:0] LoadData;
  logic         Done;

  modport master (
    output ReqRead, ReqWrite, Addr, WrData,
    input  Busy, LoadSet, LoadData, Done
  );

  modport slave (
    input  ReqRead, ReqWrite, Addr, WrData,
    output Busy, LoadSet, LoadData, Done
  );
endinterface
`default_nettype wire

// File: rtl/load_responder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// load_responder : fixed-latency data memory feeding the deferred-load port
// Rev 1.0
// ----------------------------------------------------------------------------
module load_responder #(
  parameter int W   = 8,
  parameter int A   = 8,
  parameter int LAT = 2
) (
  input  logic              Clk,
  input  logic              ResetN,
  load_responder_if.slave   Bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    SET    = 2'd2,
    DATA   = 2'd3
  } state_t;

  localparam logic [3:0] c_countInit = 4'(LAT - 1);

  state_t       r_state;
  logic [3:0]   r_count;
  logic [A-1:0] r_addr;
  logic [W-1:0] r_loadData;
  logic         r_busy;
  logic         r_loadSet;
  logic         r_done;
  logic [W-1:0] r_mem [2**A];

  logic w_idle;
  logic w_write;

  assign w_idle  = (r_state == IDLE);
  // A simultaneous read request takes priority and drops the write.
  assign w_write = w_idle & Bus.ReqWrite & ~Bus.ReqRead;

  // Memory contents deliberately survive reset.
  always_ff @(posedge Clk) begin
    if (w_write) begin
      r_mem[Bus.Addr] <= Bus.WrData;
    end
  end

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      r_state    <= IDLE;
      r_count    <= 4'd0;
      r_addr     <= '0;
      r_loadData <= '0;
      r_busy     <= 1'b0;
      r_loadSet  <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_loadSet <= 1'b0;
          if (Bus.ReqRead) begin
            r_addr  <= Bus.Addr;
            r_count <= c_countInit;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_state <= ACCESS;
          end else begin
            r_done  <= Bus.ReqWrite;
          end
        end
        ACCESS: begin
          if (r_count == 4'd0) begin
            r_loadData <= r_mem[r_addr];
            r_loadSet  <= 1'b1;
            r_state    <= SET;
          end else begin
            r_count <= r_count - 4'd1;
          end
        end
        SET: begin
          r_loadSet <= 1'b0;
          r_done    <= 1'b1;
          r_state   <= DATA;
        end
        DATA: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy    <= 1'b0;
          r_loadSet <= 1'b0;
          r_done    <= 1'b0;
          r_state   <= IDLE;
        end
      endcase
    end
  end

  assign Bus.Busy     = r_busy;
  assign Bus.LoadSet  = r_loadSet;
  assign Bus.LoadData = r_loadData;
  assign Bus.Done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_load_responder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_load_responder : directed vector bench for load_responder (LAT 1, 2, 15)
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_load_responder;

  logic       Clk;
  logic       ResetN;
  logic       reqRead;
  logic       reqWrite;
  logic [7:0] addr;
  logic [7:0] wrData;

  int total = 0;
  int bad   = 0;

  load_responder_if #(.W(8), .A(8)) bus   ();
  load_responder_if #(.W(8), .A(8)) bus1  ();
  load_responder_if #(.W(8), .A(8)) bus15 ();

  assign bus.ReqRead    = reqRead;
  assign bus.ReqWrite   = reqWrite;
  assign bus.Addr       = addr;
  assign bus.WrData     = wrData;
  assign bus1.ReqRead   = reqRead;
  assign bus1.ReqWrite  = reqWrite;
  assign bus1.Addr      = addr;
  assign bus1.WrData    = wrData;
  assign bus15.ReqRead  = reqRead;
  assign bus15.ReqWrite = reqWrite;
  assign bus15.Addr     = addr;
  assign bus15.WrData   = wrData;

  load_responder #(.W(8), .A(8), .LAT(2))  dut   (.Clk(Clk), .ResetN(ResetN), .Bus(bus));
  load_responder #(.W(8), .A(8), .LAT(1))  dut1  (.Clk(Clk), .ResetN(ResetN), .Bus(bus1));
  load_responder #(.W(8), .A(8), .LAT(15)) dut15 (.Clk(Clk), .ResetN(ResetN), .Bus(bus15));

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic       rd;
    logic       wr;
    logic [7:0] a;
    logic [7:0] d;
    logic       busy;
    logic       ls;
    logic [7:0] ld;
    logic       done;
  } vec_t;

  localparam int NVEC = 40;
  vec_t vecs [NVEC];

  function automatic vec_t mk(int rd, int wr, int a, int d, int b, int s, int l, int dn);
    vec_t v;
    v.rd   = rd[0];
    v.wr   = wr[0];
    v.a    = a[7:0];
    v.d    = d[7:0];
    v.busy = b[0];
    v.ls   = s[0];
    v.ld   = l[7:0];
    v.done = dn[0];
    return v;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [7:0] a, input logic [7:0] d);
    reqRead  = rd;
    reqWrite = wr;
    addr     = a;
    wrData   = d;
  endtask

  // Apply inputs for one edge, then look at the cycle that follows it.
  task automatic step(input logic rd, input logic wr, input logic [7:0] a, input logic [7:0] d);
    drive(rd, wr, a, d);
    @(posedge Clk);
    #1;
  endtask

  task automatic checkOut(input string tag, input logic b, input logic s, input logic [7:0] l, input logic dn);
    check({tag, ".Busy"},     8'(bus.Busy),    8'(b));
    check({tag, ".LoadSet"},  8'(bus.LoadSet), 8'(s));
    check({tag, ".LoadData"}, bus.LoadData,    l);
    check({tag, ".Done"},     8'(bus.Done),    8'(dn));
  endtask

  initial begin
    // rd wr addr data | busy ls ld done   (outputs in the cycle after the edge)
    vecs[0]  = mk(0,1,'h10,'hA5, 0,0,'h00,1);
    vecs[1]  = mk(1,0,'h10,'h00, 1,0,'h00,0);
    vecs[2]  = mk(0,0,'h00,'h00, 1,0,'h00,0);
    vecs[3]  = mk(0,0,'h00,'h00, 1,1,'hA5,0);
    vecs[4]  = mk(0,0,'h00,'h00, 1,0,'hA5,1);
    vecs[5]  = mk(0,0,'h00,'h00, 0,0,'hA5,0);
    vecs[6]  = mk(0,1,'h01,'h11, 0,0,'hA5,1);
    vecs[7]  = mk(0,1,'h02,'h22, 0,0,'hA5,1);
    vecs[8]  = mk(0,1,'h03,'h33, 0,0,'hA5,1);
    vecs[9]  = mk(1,0,'h03,'h00, 1,0,'hA5,0);
    vecs[10] = mk(0,0,'h00,'h00, 1,0,'hA5,0);
    vecs[11] = mk(0,0,'h00,'h00, 1,1,'h33,0);
    vecs[12] = mk(0,0,'h00,'h00, 1,0,'h33,1);
    vecs[13] = mk(0,0,'h00,'h00, 0,0,'h33,0);
    vecs[14] = mk(1,0,'h02,'h00, 1,0,'h33,0);
    vecs[15] = mk(0,0,'h00,'h00, 1,0,'h33,0);
    vecs[16] = mk(0,0,'h00,'h00, 1,1,'h22,0);
    vecs[17] = mk(0,0,'h00,'h00, 1,0,'h22,1);
    vecs[18] = mk(0,0,'h00,'h00, 0,0,'h22,0);
    vecs[19] = mk(1,0,'h01,'h00, 1,0,'h22,0);
    vecs[20] = mk(0,1,'h01,'hFF, 1,0,'h22,0);
    vecs[21] = mk(1,1,'h02,'hFF, 1,1,'h11,0);
    vecs[22] = mk(1,1,'h02,'hFF, 1,0,'h11,1);
    vecs[23] = mk(0,0,'h00,'h00, 0,0,'h11,0);
    vecs[24] = mk(0,1,'h05,'h5A, 0,0,'h11,1);
    vecs[25] = mk(1,1,'h05,'h77, 1,0,'h11,0);
    vecs[26] = mk(0,0,'h00,'h00, 1,0,'h11,0);
    vecs[27] = mk(0,0,'h00,'h00, 1,1,'h5A,0);
    vecs[28] = mk(0,0,'h00,'h00, 1,0,'h5A,1);
    vecs[29] = mk(0,0,'h00,'h00, 0,0,'h5A,0);
    vecs[30] = mk(1,0,'h01,'h00, 1,0,'h5A,0);
    vecs[31] = mk(0,0,'h00,'h00, 1,0,'h5A,0);
    vecs[32] = mk(0,0,'h00,'h00, 1,1,'h11,0);
    vecs[33] = mk(0,0,'h00,'h00, 1,0,'h11,1);
    vecs[34] = mk(0,0,'h00,'h00, 0,0,'h11,0);
    vecs[35] = mk(1,0,'h05,'h00, 1,0,'h11,0);
    vecs[36] = mk(0,0,'h00,'h00, 1,0,'h11,0);
    vecs[37] = mk(0,0,'h00,'h00, 1,1,'h5A,0);
    vecs[38] = mk(0,0,'h00,'h00, 1,0,'h5A,1);
    vecs[39] = mk(0,0,'h00,'h00, 0,0,'h5A,0);

    drive(1'b0, 1'b0, 8'h00, 8'h00);
    ResetN = 1'b1;
    #1 ResetN = 1'b0;
    #1;
    checkOut("reset", 1'b0, 1'b0, 8'h00, 1'b0);
    @(posedge Clk);
    @(posedge Clk);
    #1 ResetN = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      step(vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].d);
      checkOut($sformatf("vec%0d", i), vecs[i].busy, vecs[i].ls, vecs[i].ld, vecs[i].done);
    end

    // Reset in the middle of a read: outputs drop at once, no late pulses.
    step(1'b0, 1'b1, 8'h07, 8'h3C);
    checkOut("rstWr", 1'b0, 1'b0, 8'h5A, 1'b1);
    step(1'b1, 1'b0, 8'h07, 8'h00);
    step(1'b0, 1'b0, 8'h00, 8'h00);
    checkOut("rstCyc2", 1'b1, 1'b0, 8'h5A, 1'b0);
    ResetN = 1'b0;
    #1;
    checkOut("rstMid", 1'b0, 1'b0, 8'h00, 1'b0);
    #1 ResetN = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b0, 8'h00, 8'h00);
      checkOut($sformatf("rstQuiet%0d", k), 1'b0, 1'b0, 8'h00, 1'b0);
    end
    step(1'b1, 1'b0, 8'h07, 8'h00);
    checkOut("postRst1", 1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 8'h00);
    step(1'b0, 1'b0, 8'h00, 8'h00);
    checkOut("postRst3", 1'b1, 1'b1, 8'h3C, 1'b0);
    step(1'b0, 1'b0, 8'h00, 8'h00);
    checkOut("postRst4", 1'b1, 1'b0, 8'h3C, 1'b1);
    step(1'b0, 1'b0, 8'h00, 8'h00);
    checkOut("postRst5", 1'b0, 1'b0, 8'h3C, 1'b0);

    // Latency builds: all three instances idle, then one shared write and read.
    for (int k = 0; k < 20; k++) step(1'b0, 1'b0, 8'h00, 8'h00);
    step(1'b0, 1'b1, 8'h09, 8'h96);
    begin
      int   first1  = 0;
      int   first2  = 0;
      int   first15 = 0;
      logic [7:0] d1  = 8'h00;
      logic [7:0] d2  = 8'h00;
      logic [7:0] d15 = 8'h00;
      drive(1'b1, 1'b0, 8'h09, 8'h00);
      for (int k = 1; k <= 20; k++) begin
        @(posedge Clk);
        #1;
        if (k == 1) drive(1'b0, 1'b0, 8'h00, 8'h00);
        if (bus1.LoadSet  && first1  == 0) begin first1  = k; d1  = bus1.LoadData;  end
        if (bus.LoadSet   && first2  == 0) begin first2  = k; d2  = bus.LoadData;   end
        if (bus15.LoadSet && first15 == 0) begin first15 = k; d15 = bus15.LoadData; end
      end
      check("lat1.cycle",  8'(first1),  8'd2);
      check("lat1.data",   d1,          8'h96);
      check("lat2.cycle",  8'(first2),  8'd3);
      check("lat2.data",   d2,          8'h96);
      check("lat15.cycle", 8'(first15), 8'd16);
      check("lat15.data",  d15,         8'h96);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/load_responder.md
Name: load_responder

Overview:
- Data-memory responder on the load/store path feeding the register file's deferred-load interface.
- Accepts single read/write requests from the core and models a fixed multi-cycle memory latency.
- For a read, pulses LoadSet for one cycle, then drives the read word on LoadData in the following cycle. The register file latches the destination on LoadSet and writes LoadData one edge later.
- Sits between the core's memory-request decode and the register file DataIn mux.

Parameters:
W, 8, data word width in bits
A, 8, address width; memory depth 2**A words
LAT, 2, read access latency in cycles (legal range 1..15)

Ports:
Clk  input  1  clock, all state updates on rising edge
ResetN  input  1  asynchronous, active-low reset
ReqRead  input  1  read request, sampled only while Busy=0
ReqWrite  input  1  write request, sampled only while Busy=0
Addr  input  A  request address, sampled with the request
WrData  input  W  write data, sampled with ReqWrite
Busy  output  1  responder occupied; new requests ignored
LoadSet  output  1  one-cycle pulse: load data follows next cycle
LoadData  output  W  read word; valid in the cycle after LoadSet
Done  output  1  one-cycle pulse: request complete

Behaviour:
- Reset (ResetN=0, asynchronous):
  - State=IDLE; Busy, LoadSet and Done go to 0.
  - LoadData and the latched-address register go to 0.
  - Memory array is not cleared; its contents survive reset.
- States: IDLE, ACCESS, SET, DATA. A 4-bit down-counter times ACCESS.
- IDLE (Busy=0):
  - ReqRead=1 at an edge: latch Addr, load counter with LAT-1, go to ACCESS.
  - ReqWrite=1 with ReqRead=0 at an edge: mem[Addr]<=WrData at that edge, Done=1 for the next cycle, stay IDLE. Busy stays 0, so back-to-back writes on consecutive cycles are legal.
  - ReqRead and ReqWrite both 1: the read wins and the write is dropped entirely (memory unchanged).
- ACCESS (Busy=1):
  - Counter decrements by 1 each cycle.
  - At the edge where counter==0: LoadData<=mem[latched addr], go to SET.
  - The ACCESS dwell is exactly LAT cycles.
- SET (Busy=1): LoadSet=1 for exactly this cycle; LoadData already valid; next state DATA.
- DATA (Busy=1): LoadData held; Done=1 for this cycle; next state IDLE.
- Read timing, with the request sampled at edge 0:
  - Cycles 1..LAT are ACCESS.
  - Cycle LAT+1 is SET (LoadSet=1).
  - Cycle LAT+2 is DATA (Done=1).
  - Busy=0 again from cycle LAT+3.
- LoadData holds its last read value outside SET/DATA and is never changed by writes.
- Requests, Addr and WrData are ignored while Busy=1. Addr changes during a read do not affect the word returned.
- Read of an address written at an earlier edge returns the new data; there is no stale-data hazard, since a write can only complete in IDLE.
- Reset asserted mid-read: no LoadSet or Done is issued for that read. After release the block is IDLE and accepts a new request on the first edge.
- LoadSet and Done are never asserted in the same cycle. Done is asserted at most once per request.

Test Plan:
1. Write 0xA5 to addr 0x10, then read 0x10 with LAT=2 → LoadSet=1 in cycle 3 after the read edge; LoadData=0xA5 in cycles 3-4; Done=1 in cycle 4; Busy=1 in cycles 1-4 and 0 in cycle 5.
2. Writes of 0x11, 0x22, 0x33 to addrs 1, 2, 3 on consecutive cycles, then reads of 3, 2, 1 → returns 0x33, 0x22, 0x11. Done pulses once per request; Busy never asserts during the writes.
3. During a read of addr 1: drive ReqWrite to addr 1 with 0xFF and change Addr to 2 while Busy=1 → read returns 0x11 and mem[1] remains 0x11 on a later read.
4. ReqRead=1 and ReqWrite=1 together to addr 5 (old value 0x5A, WrData 0x77) → read returns 0x5A; a subsequent read of addr 5 also returns 0x5A.
5. ResetN pulsed low in cycle 2 of a read → Busy, LoadSet and Done drop immediately and no LoadSet follows. A read issued after release returns the pre-reset memory value.
6. Rebuild with LAT=1 and with LAT=15; read a known word → LoadSet appears exactly at cycle LAT+1 after the request edge in both builds.
